// File: rtl/bram_sp_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous BRAM: registered command stage, tagged read returns.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module bram_sp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  bram_en,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
);

  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  tag_rd;
  logic                  tag_id;
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic                  last;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      // On contention the requester that did not win last time goes first.
      if (req0_valid && req1_valid) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign sel_wr     = grant1 ? req1_wr    : req0_wr;
  assign sel_addr   = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;

  assign rsp0_rdata = bram_data_out;
  assign rsp1_rdata = bram_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en      <= 1'b0;
      bram_wr      <= 1'b0;
      bram_addr    <= '0;
      bram_data_in <= '0;
      tag_rd       <= 1'b0;
      tag_id       <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last         <= 1'b1;
`endif
    end else begin
      bram_en <= accept;
      bram_wr <= accept && sel_wr;
      if (accept) begin
        bram_addr    <= sel_addr;
        bram_data_in <= sel_wdata;
      end
      // Tag travels with the command stage; the BRAM returns data one cycle later.
      tag_rd     <= accept && !sel_wr;
      tag_id     <= grant1;
      rsp0_valid <= tag_rd && !tag_id;
      rsp1_valid <= tag_rd && tag_id;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      if (accept)
        last <= grant1;
`endif
    end
  end

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Self-checking bench for bram_sp_arbiter with a behavioural single-port BRAM attached.
module tb_bram_sp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_wr, req1_valid, req1_wr;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       bram_en, bram_wr;
  logic [3:0] bram_addr;
  logic [7:0] bram_data_in, bram_data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_en(bram_en), .bram_wr(bram_wr), .bram_addr(bram_addr),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 2) return 8'h55;
    if (i == 3) return 8'hAA;
    return 8'hC0 + 8'(i);
  endfunction

  // Behavioural bram_sync_sp: one-cycle read latency, preloadable.
  logic [7:0] mem [16];
  logic       init_mem = 1'b0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (bram_en) begin
      if (bram_wr) mem[bram_addr] <= bram_data_in;
      else         bram_data_out <= mem[bram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic reset_and_init();
    rst = 1'b1;
    init_mem = 1'b1;
    @(posedge clk);
    #1 init_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic v0; logic w0; logic [3:0] a0; logic [7:0] d0;
    logic v1; logic w1; logic [3:0] a1; logic [7:0] d1;
    logic r0; logic r1; logic s0; logic s1; logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(logic v0, logic w0, logic [3:0] a0, logic [7:0] d0,
                              logic v1, logic w1, logic [3:0] a1, logic [7:0] d1,
                              logic r0, logic r1, logic s0, logic s1, logic [7:0] rd);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1; v.rd = rd;
    return v;
  endfunction

  vec_t tbl [14];
  int   n_cyc;
  int   g, gp;

  initial begin
    // Expected responses belong to the command accepted two rows earlier.
    tbl[0]  = mk(1,1,4'h6,8'hA5, 0,0,4'h0,8'h00, 1,0, 0,0,8'h00); // req0 write 6=A5
    tbl[1]  = mk(1,0,4'h6,8'h00, 0,0,4'h0,8'h00, 1,0, 0,0,8'h00); // req0 read 6
    tbl[2]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,0,8'h00);
    tbl[3]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 1,0,8'hA5);
    tbl[4]  = mk(0,0,4'h0,8'h00, 1,1,4'h2,8'h3C, 0,1, 0,0,8'h00); // req1 write 2=3C
    tbl[5]  = mk(1,0,4'h2,8'h00, 0,0,4'h0,8'h00, 1,0, 0,0,8'h00); // req0 read 2
    tbl[6]  = mk(0,0,4'h0,8'h00, 1,0,4'h3,8'h00, 0,1, 0,0,8'h00); // req1 read 3
    tbl[7]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 1,0,8'h3C);
    tbl[8]  = mk(1,0,4'h9,8'h00, 1,1,4'h9,8'h77, 1,0, 0,1,8'hAA); // contention, last=1 -> req0
    tbl[9]  = mk(0,0,4'h0,8'h00, 1,1,4'h9,8'h77, 0,1, 0,0,8'h00); // req1 held, now accepted
    tbl[10] = mk(1,0,4'h9,8'h00, 0,0,4'h0,8'h00, 1,0, 1,0,8'hC9);
    tbl[11] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,0,8'h00);
    tbl[12] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 1,0,8'h77);
    tbl[13] = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,0, 0,0,8'h00);

    // Reset state, with req0 already asking
    drive(1,0,4'h0,8'h00, 0,0,4'h0,8'h00);
    rst = 1'b1;
    init_mem = 1'b1;
    #1;
    chk("reset_ready0", 32'(req0_ready), 0);
    chk("reset_bram_en", 32'(bram_en), 0);
    @(posedge clk);
    #1 init_mem = 1'b0;
    chk("reset_rsp0", 32'(rsp0_valid), 0);
    chk("reset_bram_addr", 32'(bram_addr), 0);
    drive(0,0,4'h0,8'h00, 0,0,4'h0,8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven section
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
      chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
      chk($sformatf("vec%0d_rsp0", i), 32'(rsp0_valid), 32'(tbl[i].s0));
      chk($sformatf("vec%0d_rsp1", i), 32'(rsp1_valid), 32'(tbl[i].s1));
      if (tbl[i].s0) chk($sformatf("vec%0d_rdata0", i), 32'(rsp0_rdata), 32'(tbl[i].rd));
      if (tbl[i].s1) chk($sformatf("vec%0d_rdata1", i), 32'(rsp1_rdata), 32'(tbl[i].rd));
      if (i == 1) chk("vec1_bram_wr_pulse", 32'({bram_en, bram_wr}), 32'b11);
      if (i == 2) chk("vec2_bram_read", 32'({bram_en, bram_wr, bram_addr}), 32'({2'b10, 4'h6}));
    end

    // Asynchronous reset while a read is in flight
    @(negedge clk);
    drive(1,0,4'h4,8'h00, 0,0,4'h0,8'h00);
    @(posedge clk);
    #1 chk("midrst_pre_en", 32'(bram_en), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready0", 32'(req0_ready), 0);
    chk("midrst_bram", 32'({bram_en, bram_wr, bram_addr, bram_data_in}), 0);
    @(posedge clk);
    #1 chk("midrst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("postrst_ready0", 32'(req0_ready), 1);
    @(posedge clk);
    #1 chk("postrst_cmd", 32'({bram_en, bram_addr}), 32'({1'b1, 4'h4}));
    drive(0,0,4'h0,8'h00, 0,0,4'h0,8'h00);

    // Continuous contention from reset
    @(negedge clk);
    drive(1,0,4'h2,8'h00, 1,0,4'h3,8'h00);
    reset_and_init();
`ifdef BRAM_ARB_FIXED_PRIO_EN
    n_cyc = 20;
`else
    n_cyc = 8;
`endif
    for (int c = 0; c < n_cyc; c++) begin
      if (c > 0) @(negedge clk);
      #1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
      g = 0; gp = 0;
`else
      g = c % 2; gp = (c + 2) % 2;
`endif
      chk($sformatf("rr%0d_ready0", c), 32'(req0_ready), 32'(g == 0));
      chk($sformatf("rr%0d_ready1", c), 32'(req1_ready), 32'(g == 1));
      if (c < 2) begin
        chk($sformatf("rr%0d_norsp", c), 32'({rsp0_valid, rsp1_valid}), 0);
      end else begin
        chk($sformatf("rr%0d_rsp0", c), 32'(rsp0_valid), 32'(gp == 0));
        chk($sformatf("rr%0d_rsp1", c), 32'(rsp1_valid), 32'(gp == 1));
        chk($sformatf("rr%0d_rdata", c), 32'(rsp0_rdata), (gp == 0) ? 32'h55 : 32'hAA);
      end
    end
    @(negedge clk);
    drive(0,0,4'h0,8'h00, 1,0,4'h3,8'h00);
    #1 chk("drop0_ready1", 32'(req1_ready), 1);

    // Back-to-back reads 0..15 from requester 0
    @(negedge clk);
    drive(0,0,4'h0,8'h00, 0,0,4'h0,8'h00);
    reset_and_init();
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 16) drive(1,0,4'(c),8'h00, 0,0,4'h0,8'h00);
      else        drive(0,0,4'h0,8'h00, 0,0,4'h0,8'h00);
      #1;
      if (c < 16) chk($sformatf("b2b%0d_ready0", c), 32'(req0_ready), 1);
      if (c >= 2) begin
        chk($sformatf("b2b%0d_rsp0", c), 32'(rsp0_valid), 1);
        chk($sformatf("b2b%0d_rdata", c), 32'(rsp0_rdata), 32'(init_val(c - 2)));
      end
      chk($sformatf("b2b%0d_rsp1", c), 32'(rsp1_valid), 0);
    end
    @(negedge clk);
    #1 chk("b2b_end_rsp0", 32'(rsp0_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
